// File: rtl/fifo4_reader_if.sv
// Bundle of the FIFO4 read-side and byte-consumer signals for fifo4_reader.
// The master modport is the reader itself; the slave modport is the
// FIFO/consumer side. byte_par exists only when FIFO4_READER_PARITY_EN
// is defined.
interface fifo4_reader_if;
    logic [3:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_read;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_cnt;
    logic       stall_seen;
`ifdef FIFO4_READER_PARITY_EN
    logic       byte_par;
`endif

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_full,
        input  byte_ready,
        output fifo_read,
        output byte_out,
        output byte_valid,
        output byte_cnt,
        output stall_seen
`ifdef FIFO4_READER_PARITY_EN
        ,
        output byte_par
`endif
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_full,
        output byte_ready,
        input  fifo_read,
        input  byte_out,
        input  byte_valid,
        input  byte_cnt,
        input  stall_seen
`ifdef FIFO4_READER_PARITY_EN
        ,
        input  byte_par
`endif
    );
endinterface

// File: rtl/fifo4_reader.sv
// fifo4_reader: pops two nibbles from a FIFO4 (read data arrives the cycle
// after the pop), assembles them into a byte and holds it until the
// consumer accepts it. Counts accepted bytes and remembers any FIFO-full.
// Optional feature macro: FIFO4_READER_PARITY_EN adds byte_par, the odd
// parity (XNOR-reduce) of each assembled byte.
module fifo4_reader #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          clr,
    fifo4_reader_if.master bus
);

    typedef enum logic [2:0] {
        S_REQ0 = 3'd0,
        S_CAP0 = 3'd1,
        S_REQ1 = 3'd2,
        S_CAP1 = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] nib0_q, nib0_d;
    logic [3:0] nib1_q, nib1_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       stall_seen_q, stall_seen_d;
    logic       fifo_read;
    logic [7:0] assembled;
`ifdef FIFO4_READER_PARITY_EN
    logic       byte_par_q, byte_par_d;
`endif

    // State register; clr forces a fresh byte from S_REQ0.
    always_ff @(posedge clk) begin
        if (clr) state_q <= S_REQ0;
        else     state_q <= state_d;
    end

    // Next-state: pop states wait on empty, capture states advance, hold waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ0:  if (!bus.fifo_empty) state_d = S_CAP0;
            S_CAP0:  state_d = S_REQ1;
            S_REQ1:  if (!bus.fifo_empty) state_d = S_CAP1;
            S_CAP1:  state_d = S_HOLD;
            S_HOLD:  if (bus.byte_ready) state_d = S_REQ0;
            default: state_d = S_REQ0;
        endcase
    end

    // Output decode: pop only from a request state with data available, never under clr.
    always_comb begin
        fifo_read = 1'b0;
        if (!clr && !bus.fifo_empty &&
            (state_q == S_REQ0 || state_q == S_REQ1)) begin
            fifo_read = 1'b1;
        end
    end

    // Byte assembly; the second nibble comes straight from the FIFO in S_CAP1.
    always_comb begin
        if (LOW_FIRST) assembled = {nib1_d, nib0_q};
        else           assembled = {nib0_q, nib1_d};
    end

    // Datapath next values: nibble capture, byte load, handshake, counters and sticky stall.
    always_comb begin
        nib0_d       = nib0_q;
        nib1_d       = nib1_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        byte_cnt_d   = byte_cnt_q;
        stall_seen_d = stall_seen_q | bus.fifo_full;
`ifdef FIFO4_READER_PARITY_EN
        byte_par_d   = byte_par_q;
`endif
        case (state_q)
            S_CAP0: nib0_d = bus.fifo_dout;
            S_CAP1: begin
                nib1_d       = bus.fifo_dout;
                byte_out_d   = assembled;
                byte_valid_d = 1'b1;
`ifdef FIFO4_READER_PARITY_EN
                byte_par_d   = ~^assembled;
`endif
            end
            S_HOLD: begin
                if (bus.byte_ready) begin
                    byte_valid_d = 1'b0;
                    byte_cnt_d   = byte_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; clr discards partial nibbles and any unaccepted byte.
    always_ff @(posedge clk) begin
        if (clr) begin
            nib0_q       <= 4'd0;
            nib1_q       <= 4'd0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_cnt_q   <= 8'd0;
            stall_seen_q <= 1'b0;
        end else begin
            nib0_q       <= nib0_d;
            nib1_q       <= nib1_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            stall_seen_q <= stall_seen_d;
        end
    end

`ifdef FIFO4_READER_PARITY_EN
    // Parity register, loaded alongside byte_out.
    always_ff @(posedge clk) begin
        if (clr) byte_par_q <= 1'b0;
        else     byte_par_q <= byte_par_d;
    end

    assign bus.byte_par = byte_par_q;
`endif

    assign bus.fifo_read  = fifo_read;
    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_cnt   = byte_cnt_q;
    assign bus.stall_seen = stall_seen_q;

endmodule

// File: tb/tb_fifo4_reader.sv
// Directed bench for fifo4_reader. Two instances run in lockstep on the
// same FIFO model: dut0 with LOW_FIRST=1 (drives the pops) and dut1 with
// LOW_FIRST=0 (same inputs, so its byte_out must be nibble-swapped).
module tb_fifo4_reader;

    logic clk;
    logic clr;

    fifo4_reader_if if0 ();
    fifo4_reader_if if1 ();

    fifo4_reader #(.LOW_FIRST(1'b1)) dut0 (.clk(clk), .clr(clr), .bus(if0));
    fifo4_reader #(.LOW_FIRST(1'b0)) dut1 (.clk(clk), .clr(clr), .bus(if1));

    // FIFO model: array with write pointer (bench) and read pointer (pops).
    logic [3:0] mem [0:1023];
    int         wr_ptr;
    int         rd_ptr;
    logic [3:0] dout;
    logic       full_in;
    logic       ready_in;

    assign if0.fifo_dout  = dout;
    assign if0.fifo_empty = (wr_ptr == rd_ptr);
    assign if0.fifo_full  = full_in;
    assign if0.byte_ready = ready_in;
    assign if1.fifo_dout  = dout;
    assign if1.fifo_empty = (wr_ptr == rd_ptr);
    assign if1.fifo_full  = full_in;
    assign if1.byte_ready = ready_in;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if0.fifo_read) begin
            dout   <= mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor of pre-edge values: pop count, back-to-back pops, pop spacing, valid cycles.
    int cyc, read_cnt, b2b, gap, last_rd, vcyc;
    logic prev_read;
    initial begin
        cyc = 0; read_cnt = 0; b2b = 0; gap = 0; last_rd = 0; vcyc = 0; prev_read = 1'b0;
    end
    always @(posedge clk) begin
        if (if0.fifo_read) begin
            read_cnt++;
            if (prev_read) b2b++;
            gap     = cyc - last_rd;
            last_rd = cyc;
        end
        prev_read = if0.fifo_read;
        if (if0.byte_valid) vcyc++;
        cyc++;
    end

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!if0.byte_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    int n, r0, v0, stable;

    initial begin
        n_tests = 0; n_fail = 0;
        clk = 1'b0; clr = 1'b1; full_in = 1'b0; ready_in = 1'b1;
        wr_ptr = 0; rd_ptr = 0; dout = 4'd0;
        tick(); tick();

        // Reset state, with data waiting in the FIFO: no pop while clr is high.
        push(4'hA); push(4'h5);
        tick();
        check("rst_valid", {31'd0, if0.byte_valid}, 32'd0);
        check("rst_cnt", {24'd0, if0.byte_cnt}, 32'd0);
        check("rst_out", {24'd0, if0.byte_out}, 32'd0);
        check("rst_stall", {31'd0, if0.stall_seen}, 32'd0);
        check("rst_read", {31'd0, if0.fifo_read}, 32'd0);

        // Basic byte: A then 5, consumer always ready.
        r0 = read_cnt; v0 = vcyc;
        clr = 1'b0;
        wait_valid(20, n);
        check("t1_latency", n, 32'd4);
        check("t1_valid", {31'd0, if0.byte_valid}, 32'd1);
        check("t1_byte_lo", {24'd0, if0.byte_out}, 32'h5A);
        check("t1_byte_hi", {24'd0, if1.byte_out}, 32'hA5);
`ifdef FIFO4_READER_PARITY_EN
        check("t1_par", {31'd0, if0.byte_par}, 32'd1);
`endif
        tick();
        check("t1_valid_drop", {31'd0, if0.byte_valid}, 32'd0);
        check("t1_cnt", {24'd0, if0.byte_cnt}, 32'd1);
        check("t1_reads", read_cnt - r0, 32'd2);
        check("t1_gap", gap, 32'd2);
        check("t1_vcycles", vcyc - v0, 32'd1);

        // Empty after first nibble: wait in S_REQ1 with no pops, then finish the byte.
        push(4'h7);
        tick(); tick();
        r0 = read_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("t2_no_reads", read_cnt - r0, 32'd0);
        check("t2_no_valid", {31'd0, if0.byte_valid}, 32'd0);
        push(4'h3);
        wait_valid(20, n);
        check("t2_valid", {31'd0, if0.byte_valid}, 32'd1);
        check("t2_byte_lo", {24'd0, if0.byte_out}, 32'h37);
        check("t2_byte_hi", {24'd0, if1.byte_out}, 32'h73);
`ifdef FIFO4_READER_PARITY_EN
        check("t2_par", {31'd0, if0.byte_par}, 32'd0);
`endif
        tick();
        check("t2_cnt", {24'd0, if0.byte_cnt}, 32'd2);

        // Consumer stalls 7 cycles with more data queued: byte stable, no pops.
        ready_in = 1'b0;
        push(4'h2); push(4'hC);
        wait_valid(20, n);
        check("t3_valid", {31'd0, if0.byte_valid}, 32'd1);
        push(4'h9);
        r0 = read_cnt; stable = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (if0.byte_out == 8'hC2 && if0.byte_valid) stable++;
        end
        check("t3_stable", stable, 32'd7);
        check("t3_cnt_held", {24'd0, if0.byte_cnt}, 32'd2);
        ready_in = 1'b1;
        tick();
        check("t3_no_reads", read_cnt - r0, 32'd0);
        check("t3_cnt", {24'd0, if0.byte_cnt}, 32'd3);
        check("t3_valid_drop", {31'd0, if0.byte_valid}, 32'd0);

        // clr while holding 8'h19 (ready high in the same cycle): nothing counted, no pop under clr.
        ready_in = 1'b0;
        push(4'h1);
        wait_valid(20, n);
        check("t4_byte", {24'd0, if0.byte_out}, 32'h19);
        push(4'hE); push(4'h6);
        r0 = read_cnt;
        clr = 1'b1; ready_in = 1'b1;
        tick();
        check("t4_valid", {31'd0, if0.byte_valid}, 32'd0);
        check("t4_cnt", {24'd0, if0.byte_cnt}, 32'd0);
        check("t4_out", {24'd0, if0.byte_out}, 32'd0);
        check("t4_read_clr", {31'd0, if0.fifo_read}, 32'd0);
        tick();
        check("t4_no_reads", read_cnt - r0, 32'd0);
        clr = 1'b0;
        wait_valid(20, n);
        check("t4_latency", n, 32'd4);
        check("t4_byte_after", {24'd0, if0.byte_out}, 32'h6E);
        tick();
        check("t4_cnt_after", {24'd0, if0.byte_cnt}, 32'd1);

        // Sticky stall flag from a single cycle of fifo_full.
        full_in = 1'b1;
        tick();
        full_in = 1'b0;
        check("t5_stall_set", {31'd0, if0.stall_seen}, 32'd1);
        tick(); tick();
        check("t5_stall_hold", {31'd0, if0.stall_seen}, 32'd1);

        // Stream 255 more bytes at full rate: count wraps 255 -> 0.
        for (int i = 0; i < 510; i++) push(i[3:0]);
        n = 0;
        do begin
            tick();
            n++;
        end while (if0.byte_cnt != 8'd0 && n < 2000);
        check("t6_cycles", n, 32'd1275);
        check("t6_cnt_wrap", {24'd0, if0.byte_cnt}, 32'd0);
        check("t6_last_lo", {24'd0, if0.byte_out}, 32'hDC);
        check("t6_last_hi", {24'd0, if1.byte_out}, 32'hCD);
        check("t6_no_b2b", b2b, 32'd0);
        check("t6_stall", {31'd0, if0.stall_seen}, 32'd1);

        clr = 1'b1;
        tick();
        check("t6_stall_clr", {31'd0, if0.stall_seen}, 32'd0);
        clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo4_reader.md
FIFO4_READER -- requirements
Module: fifo4_reader

Interface
REQ-001 Parameter LOW_FIRST, default 1: 1 places the first nibble popped in byte_out[3:0]; 0 places it in byte_out[7:4].
REQ-002 The port clk SHALL be an input, 1 bit wide, and the single clock; all state updates on its rising edge.
REQ-003 The port clr SHALL be an input, 1 bit wide, and a synchronous, active-high reset.
REQ-004 The port fifo_dout SHALL be an input, 4 bits wide, carrying data from the FIFO4 read port, valid the cycle after fifo_read is high.
REQ-005 The port fifo_empty SHALL be an input, 1 bit wide, carrying the FIFO4 empty flag.
REQ-006 The port fifo_full SHALL be an input, 1 bit wide, carrying the FIFO4 full flag, and SHALL only be used to drive stall_seen.
REQ-007 The port fifo_read SHALL be an output, 1 bit wide, giving a one-cycle pop request to FIFO4.
REQ-008 The port byte_out SHALL be an output, 8 bits wide, carrying the assembled byte.
REQ-009 The port byte_valid SHALL be an output, 1 bit wide, that is high while byte_out holds an unconsumed byte.
REQ-010 The port byte_ready SHALL be an input, 1 bit wide, driven high by the consumer when it accepts the byte.
REQ-011 The port byte_cnt SHALL be an output, 8 bits wide, counting accepted bytes.
REQ-012 The port stall_seen SHALL be an output, 1 bit wide, acting as a sticky flag that is set when fifo_full is seen high.

Function
REQ-013 The block SHALL use a registered FSM with states S_REQ0, S_CAP0, S_REQ1, S_CAP1, S_HOLD.
REQ-014 In S_REQ0, fifo_read SHALL be high combinationally iff fifo_empty=0, with next state S_CAP0; if fifo_empty=1, fifo_read SHALL be 0 and the state SHALL remain S_REQ0.
REQ-015 In S_CAP0, the block SHALL latch fifo_dout into nib0 and go to S_REQ1.
REQ-016 S_REQ1 SHALL behave as S_REQ0, moving to S_CAP1 on a pop.
REQ-017 In S_CAP1, the block SHALL latch fifo_dout into nib1, load byte_out ({nib1,nib0} if LOW_FIRST=1, else {nib0,nib1}), set byte_valid=1, and go to S_HOLD.
REQ-018 In S_HOLD, byte_out and byte_valid SHALL stay stable; fifo_read SHALL be 0.
REQ-019 The byte handshake SHALL complete on the edge where byte_valid=1 and byte_ready=1: byte_valid SHALL go 0, byte_cnt SHALL increment, and the state SHALL go to S_REQ0.
REQ-020 byte_ready SHALL be ignored outside S_HOLD; the block SHALL NOT combinationally depend on byte_ready.
REQ-021 Minimum latency SHALL be 5 cycles per byte when the FIFO is never empty and byte_ready is tied to 1.
REQ-022 Empty mid-byte (after nib0 captured) SHALL wait in S_REQ1 indefinitely with nib0 preserved.
REQ-023 fifo_read SHALL never be high in two consecutive cycles.
REQ-024 byte_cnt SHALL wrap from 255 to 0 modulo 256 with no flag.
REQ-025 stall_seen SHALL be set on any cycle with fifo_full=1 and cleared only by clr.

Reset
REQ-026 When clr=1 at a rising edge: state SHALL be S_REQ0; byte_out, nib0, and nib1 SHALL be 0; byte_valid, byte_cnt, and stall_seen SHALL be 0.
REQ-027 fifo_read SHALL be 0 in any cycle where clr=1.
REQ-028 Reset mid-operation SHALL discard any partial nibble and any unaccepted byte, and byte_cnt SHALL NOT increment.
REQ-029 clr SHALL take priority over byte_ready and fifo_empty in the same cycle.

Configuration
REQ-030 The macro FIFO4_READER_PARITY_EN, when defined, SHALL add output byte_par (1 bit), loaded in S_CAP1 with the odd parity of the new byte_out (XNOR-reduce) and reset to 0.
REQ-031 When FIFO4_READER_PARITY_EN is undefined, the byte_par port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 With the FIFO preloaded with 4'hA then 4'h5, LOW_FIRST=1, and byte_ready=1: byte_out=8'h5A, byte_valid high for 1 cycle, byte_cnt=1, and two fifo_read pulses 2 cycles apart.
REQ-033 With LOW_FIRST=0 and the same data: byte_out=8'hA5.
REQ-034 With fifo_empty=1 after the first nibble for 10 cycles, then the second nibble 4'h3 arrives: the state holds in S_REQ1 with no fifo_read, and byte_out={4'h3,first}.
REQ-035 With byte_ready=0 for 7 cycles after byte_valid rises: byte_out stays stable, there are no pops, and on the 8th cycle with byte_ready=1 the byte is accepted and byte_cnt increments once.
REQ-036 With 256 bytes streamed: byte_cnt returns to 0; stall_seen=1 after one cycle of fifo_full=1, and it persists until clr.
REQ-037 With clr pulsed in S_HOLD: byte_valid=0, byte_cnt=0 the next cycle, and no handshake counted; with FIFO4_READER_PARITY_EN defined, byte 8'h5A gives byte_par=1 and 8'h5B gives byte_par=0.
